// File: rtl/wm8960_config_sequencer.sv
// Purpose: boot-time WM8960 register-table sequencer (ACK check + retry), then a single-outstanding host forwarder to the i2c master.
// Latency: host accept -> i2c_din_valid 1 cycle; i2c dout handshake -> host_rsp_valid 1 cycle; init check adds 1 cycle per entry.
// Backpressure: din fields held until i2c_din_ready; host_ready only in S_READY; response held until host_rsp_ready.
// Optional build macro: WM8960_SEQ_TIMEOUT_EN adds a response watchdog in the wait states.
module wm8960_config_sequencer #(
  parameter logic [6:0] G_DEVICE_ADDRESS = 7'h1A,
  parameter int         G_MAX_RETRIES    = 3,
  parameter int         G_RESET_WAIT     = 1000,
  parameter int         G_TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       host_rd_wr,
  input  logic [6:0] host_reg_addr,
  input  logic [8:0] host_reg_data,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [8:0] host_rsp_data,
  output logic [2:0] host_rsp_acks,
  output logic       host_rsp_valid,
  input  logic       host_rsp_ready,
  output logic [6:0] i2c_device_address,
  output logic       i2c_rd_wr,
  output logic [6:0] i2c_register_address,
  output logic [8:0] i2c_register_data,
  output logic       i2c_din_valid,
  input  logic       i2c_din_ready,
  input  logic [8:0] i2c_dout_register_data,
  input  logic [2:0] i2c_dout_acks,
  input  logic       i2c_dout_valid,
  output logic       i2c_dout_ready,
  output logic       init_done,
  output logic       init_error,
  output logic [3:0] init_error_index
);

  localparam logic [3:0]  MAX_RETRIES     = 4'(G_MAX_RETRIES);
  localparam logic [3:0]  LAST_INDEX      = 4'd8;
  localparam logic [3:0]  DONE_INDEX      = 4'd9;
  localparam logic [31:0] RESET_WAIT_LAST = (G_RESET_WAIT > 0) ? 32'(G_RESET_WAIT - 1) : 32'd0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_INIT_CHECK,
    S_RESET_WAIT,
    S_READY,
    S_HOST_ISSUE,
    S_HOST_WAIT,
    S_HOST_RSP
  } state_t;

  state_t      state, state_d;
  logic [3:0]  index;
  logic [3:0]  retries;
  logic [31:0] wait_cnt;
  logic [2:0]  acks_q;
  logic        host_rd_wr_q;
  logic [6:0]  host_addr_q;
  logic [8:0]  host_data_q;
  logic [15:0] cur_entry;
  logic        dout_hs;
  logic        ack_ok;
  logic        retry;
  logic        timeout_hit;

  // Init table packed as {register address, register data}; out-of-range index yields zero.
  function automatic logic [15:0] init_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    init_entry = {7'd15, 9'h000};  // soft reset
      4'd1:    init_entry = {7'd25, 9'h0FC};
      4'd2:    init_entry = {7'd26, 9'h1F8};
      4'd3:    init_entry = {7'd47, 9'h00C};
      4'd4:    init_entry = {7'd4,  9'h000};
      4'd5:    init_entry = {7'd7,  9'h00A};
      4'd6:    init_entry = {7'd5,  9'h000};
      4'd7:    init_entry = {7'd34, 9'h100};
      4'd8:    init_entry = {7'd37, 9'h100};
      default: init_entry = 16'h0000;
    endcase
  endfunction

  assign cur_entry          = init_entry(index);
  assign i2c_device_address = G_DEVICE_ADDRESS;
  assign dout_hs            = i2c_dout_valid & i2c_dout_ready;
  assign ack_ok             = (acks_q == 3'b111);
  // A NACKed entry is re-issued while retry budget remains; otherwise the table moves on.
  assign retry              = !ack_ok && (retries < MAX_RETRIES);

`ifdef WM8960_SEQ_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = (G_TIMEOUT_CYCLES > 0) ? 32'(G_TIMEOUT_CYCLES - 1) : 32'd0;
  // A real response in the same cycle wins over the watchdog.
  assign timeout_hit = ((state == S_INIT_WAIT) || (state == S_HOST_WAIT)) &&
                       !i2c_dout_valid && (wait_cnt >= TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next-state decode and state-derived handshake/din outputs.
  always_comb begin
    state_d              = state;
    i2c_din_valid        = 1'b0;
    i2c_rd_wr            = 1'b0;
    i2c_register_address = 7'd0;
    i2c_register_data    = 9'd0;
    i2c_dout_ready       = 1'b0;
    host_ready           = 1'b0;
    host_rsp_valid       = 1'b0;
    case (state)
      S_IDLE: state_d = S_INIT_ISSUE;
      S_INIT_ISSUE: begin
        i2c_din_valid        = 1'b1;
        i2c_register_address = cur_entry[15:9];
        i2c_register_data    = cur_entry[8:0];
        if (i2c_din_ready) state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        i2c_dout_ready = 1'b1;
        if (i2c_dout_valid || timeout_hit) state_d = S_INIT_CHECK;
      end
      S_INIT_CHECK: begin
        if (retry)                    state_d = S_INIT_ISSUE;
        else if (index == 4'd0)       state_d = S_RESET_WAIT;
        else if (index >= LAST_INDEX) state_d = S_READY;
        else                          state_d = S_INIT_ISSUE;
      end
      S_RESET_WAIT: begin
        if (wait_cnt >= RESET_WAIT_LAST) state_d = S_INIT_ISSUE;
      end
      S_READY: begin
        host_ready = 1'b1;
        if (host_valid) state_d = S_HOST_ISSUE;
      end
      S_HOST_ISSUE: begin
        i2c_din_valid        = 1'b1;
        i2c_rd_wr            = host_rd_wr_q;
        i2c_register_address = host_addr_q;
        i2c_register_data    = host_data_q;
        if (i2c_din_ready) state_d = S_HOST_WAIT;
      end
      S_HOST_WAIT: begin
        i2c_dout_ready = 1'b1;
        if (i2c_dout_valid || timeout_hit) state_d = S_HOST_RSP;
      end
      S_HOST_RSP: begin
        host_rsp_valid = 1'b1;
        if (host_rsp_ready) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
    if (!enable) state_d = S_IDLE;
  end

  // Datapath: table index, retries, wait counter, captured responses and sticky init status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index            <= 4'd0;
      retries          <= 4'd0;
      wait_cnt         <= 32'd0;
      acks_q           <= 3'b000;
      host_rd_wr_q     <= 1'b0;
      host_addr_q      <= 7'd0;
      host_data_q      <= 9'd0;
      host_rsp_data    <= 9'd0;
      host_rsp_acks    <= 3'b000;
      init_done        <= 1'b0;
      init_error       <= 1'b0;
      init_error_index <= 4'hF;
    end else if (!enable) begin
      index            <= 4'd0;
      retries          <= 4'd0;
      wait_cnt         <= 32'd0;
      acks_q           <= 3'b000;
      host_rd_wr_q     <= 1'b0;
      host_addr_q      <= 7'd0;
      host_data_q      <= 9'd0;
      host_rsp_data    <= 9'd0;
      host_rsp_acks    <= 3'b000;
      init_done        <= 1'b0;
      init_error       <= 1'b0;
      init_error_index <= 4'hF;
    end else begin
      case (state)
        S_INIT_ISSUE, S_HOST_ISSUE: begin
          if (i2c_din_ready) wait_cnt <= 32'd0;
        end
        S_INIT_WAIT: begin
          if (wait_cnt != 32'hFFFF_FFFF) wait_cnt <= wait_cnt + 32'd1;
          if (dout_hs)          acks_q <= i2c_dout_acks;
          else if (timeout_hit) acks_q <= 3'b000;
        end
        S_INIT_CHECK: begin
          wait_cnt <= 32'd0;
          if (retry) begin
            retries <= retries + 4'd1;
          end else begin
            retries <= 4'd0;
            if (!ack_ok) begin
              init_error <= 1'b1;
              if (init_error_index == 4'hF) init_error_index <= index;
            end
            if (index != DONE_INDEX) index <= index + 4'd1;
            if (index >= LAST_INDEX) init_done <= 1'b1;
          end
        end
        S_RESET_WAIT: begin
          if (wait_cnt != 32'hFFFF_FFFF) wait_cnt <= wait_cnt + 32'd1;
        end
        S_READY: begin
          if (host_valid) begin
            host_rd_wr_q <= host_rd_wr;
            host_addr_q  <= host_reg_addr;
            host_data_q  <= host_reg_data;
          end
        end
        S_HOST_WAIT: begin
          if (wait_cnt != 32'hFFFF_FFFF) wait_cnt <= wait_cnt + 32'd1;
          if (dout_hs) begin
            host_rsp_data <= i2c_dout_register_data;
            host_rsp_acks <= i2c_dout_acks;
          end else if (timeout_hit) begin
            host_rsp_data <= 9'd0;
            host_rsp_acks <= 3'b000;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wm8960_config_sequencer.sv
// Directed bench for wm8960_config_sequencer with a small i2c master response model.
// Define WM8960_SEQ_TIMEOUT_EN on both files to include the watchdog step.
module tb_wm8960_config_sequencer;

  localparam int RESET_WAIT = 20;
  localparam int TIMEOUT    = 50;

  logic       clk = 1'b0;
  logic       reset_n, enable;
  logic       host_rd_wr, host_valid, host_ready, host_rsp_valid, host_rsp_ready;
  logic [6:0] host_reg_addr;
  logic [8:0] host_reg_data, host_rsp_data;
  logic [2:0] host_rsp_acks;
  logic [6:0] i2c_device_address, i2c_register_address;
  logic       i2c_rd_wr, i2c_din_valid, i2c_dout_ready;
  logic       i2c_din_ready = 1'b1;
  logic [8:0] i2c_register_data;
  logic [8:0] i2c_dout_register_data = 9'd0;
  logic [2:0] i2c_dout_acks = 3'b000;
  logic       i2c_dout_valid = 1'b0;
  logic       init_done, init_error;
  logic [3:0] init_error_index;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Response model state and transaction log
  int         delay = 0;
  bit         drop_next = 0;
  bit         silent = 0;
  logic [2:0] pend_acks = 3'b111;
  logic [8:0] pend_data = 9'd0;
  logic [6:0] nack_addr = 7'h7F;
  int         nack_left = 0;
  logic [8:0] read_value = 9'h0AB;
  logic [6:0] log_addr[$];
  logic [8:0] log_data[$];
  logic       log_rw[$];
  int         log_cyc[$];

  logic [6:0] exp_addr[9] = '{7'd15, 7'd25, 7'd26, 7'd47, 7'd4, 7'd7, 7'd5, 7'd34, 7'd37};
  logic [8:0] exp_data[9] = '{9'h000, 9'h0FC, 9'h1F8, 9'h00C, 9'h000, 9'h00A, 9'h000, 9'h100, 9'h100};

  wm8960_config_sequencer #(
    .G_DEVICE_ADDRESS(7'h1A),
    .G_MAX_RETRIES(3),
    .G_RESET_WAIT(RESET_WAIT),
    .G_TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .host_rd_wr(host_rd_wr), .host_reg_addr(host_reg_addr), .host_reg_data(host_reg_data),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_rsp_data(host_rsp_data), .host_rsp_acks(host_rsp_acks),
    .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
    .i2c_device_address(i2c_device_address), .i2c_rd_wr(i2c_rd_wr),
    .i2c_register_address(i2c_register_address), .i2c_register_data(i2c_register_data),
    .i2c_din_valid(i2c_din_valid), .i2c_din_ready(i2c_din_ready),
    .i2c_dout_register_data(i2c_dout_register_data), .i2c_dout_acks(i2c_dout_acks),
    .i2c_dout_valid(i2c_dout_valid), .i2c_dout_ready(i2c_dout_ready),
    .init_done(init_done), .init_error(init_error), .init_error_index(init_error_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // i2c master model: logs each din handshake, answers two cycles later unless silent.
  always @(negedge clk) begin
    if (!reset_n) begin
      i2c_dout_valid = 1'b0;
      delay = 0;
      drop_next = 1'b0;
    end else begin
      if (drop_next) begin
        i2c_dout_valid = 1'b0;
        drop_next = 1'b0;
      end
      if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          i2c_dout_valid = 1'b1;
          i2c_dout_acks = pend_acks;
          i2c_dout_register_data = pend_data;
        end
      end
      if (i2c_dout_valid && i2c_dout_ready) drop_next = 1'b1;
      if (i2c_din_valid && i2c_din_ready) begin
        log_addr.push_back(i2c_register_address);
        log_data.push_back(i2c_register_data);
        log_rw.push_back(i2c_rd_wr);
        log_cyc.push_back(cyc);
        pend_data = i2c_rd_wr ? read_value : 9'd0;
        if (i2c_register_address == nack_addr && nack_left != 0) begin
          pend_acks = 3'b011;
          if (nack_left > 0) nack_left--;
        end else begin
          pend_acks = 3'b111;
        end
        if (!silent) delay = 2;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic restart(input logic [6:0] na, input int nl);
    @(negedge clk);
    reset_n = 1'b0;
    enable = 1'b0;
    host_valid = 1'b0;
    repeat (3) @(negedge clk);
    log_addr.delete(); log_data.delete(); log_rw.delete(); log_cyc.delete();
    nack_addr = na;
    nack_left = nl;
    silent = 1'b0;
    reset_n = 1'b1;
    enable = 1'b1;
  endtask

  task automatic wait_init_done(input string tag);
    for (int i = 0; i < 3000 && init_done !== 1'b1; i++) @(negedge clk);
    check(tag, init_done, 1);
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 300 && host_rsp_valid !== 1'b1; i++) @(negedge clk);
    check(tag, host_rsp_valid, 1);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int r7_count;
    int wcount;
    reset_n = 1'b0; enable = 1'b0;
    host_valid = 1'b0; host_rd_wr = 1'b0; host_reg_addr = 7'd0; host_reg_data = 9'd0;
    host_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_init_done", init_done, 0);
    check("rst_init_error", init_error, 0);
    check("rst_err_index", init_error_index, 4'hF);
    check("rst_din_valid", i2c_din_valid, 0);
    check("rst_dout_ready", i2c_dout_ready, 0);
    check("rst_host_ready", host_ready, 0);
    check("rst_rsp_valid", host_rsp_valid, 0);
    check("rst_dev_addr", i2c_device_address, 7'h1A);
    check("rst_reg_addr", i2c_register_address, 0);

    // enable=0 holds the sequencer idle
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_din_valid", i2c_din_valid, 0);
    check("idle_log_empty", log_addr.size(), 0);

    // Step 1: all ACK, table order and soft-reset gap
    enable = 1'b1;
    wait_init_done("t1_init_done");
    check("t1_count", log_addr.size(), 9);
    for (int i = 0; i < 9 && i < log_addr.size(); i++) begin
      check($sformatf("t1_addr%0d", i), log_addr[i], exp_addr[i]);
      check($sformatf("t1_data%0d", i), log_data[i], exp_data[i]);
      check($sformatf("t1_rw%0d", i), log_rw[i], 0);
    end
    if (log_cyc.size() >= 2) check("t1_reset_gap", (log_cyc[1] - log_cyc[0]) >= RESET_WAIT, 1);
    else check("t1_reset_gap_entries", log_cyc.size(), 2);
    check("t1_init_error", init_error, 0);
    check("t1_err_index", init_error_index, 4'hF);
    check("t1_host_ready", host_ready, 1);

    // Step 4: host read R7, response held 5 cycles
    log_addr.delete(); log_data.delete(); log_rw.delete(); log_cyc.delete();
    host_rd_wr = 1'b1; host_reg_addr = 7'd7; host_reg_data = 9'd0; host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    check("t4_issue_latency", i2c_din_valid, 1);
    check("t4_fwd_addr", i2c_register_address, 7'd7);
    check("t4_fwd_rw", i2c_rd_wr, 1);
    check("t4_busy_host_ready", host_ready, 0);
    wait_rsp("t4_rsp_valid");
    check("t4_rsp_data", host_rsp_data, 9'h0AB);
    check("t4_rsp_acks", host_rsp_acks, 3'b111);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold_valid%0d", i), host_rsp_valid, 1);
      check($sformatf("t4_hold_data%0d", i), host_rsp_data, 9'h0AB);
    end
    host_rsp_ready = 1'b1;
    @(negedge clk);
    host_rsp_ready = 1'b0;
    check("t4_rsp_drop", host_rsp_valid, 0);
    check("t4_back_ready", host_ready, 1);

    // Host write R5 = 0x123
    host_rd_wr = 1'b0; host_reg_addr = 7'd5; host_reg_data = 9'h123; host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    wait_rsp("t4w_rsp_valid");
    check("t4w_rsp_acks", host_rsp_acks, 3'b111);
    check("t4w_log_count", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      check("t4w_log_addr", log_addr[1], 7'd5);
      check("t4w_log_data", log_data[1], 9'h123);
      check("t4w_log_rw", log_rw[1], 0);
    end
    host_rsp_ready = 1'b1;
    @(negedge clk);
    host_rsp_ready = 1'b0;

    // Step 2: entry 3 NACKs twice then ACKs
    restart(7'd47, 2);
    repeat (4) @(negedge clk);
    check("t2_no_host_before_done", host_ready, 0);
    wait_init_done("t2_init_done");
    check("t2_count", log_addr.size(), 11);
    if (log_addr.size() == 11) begin
      check("t2_r47_a", log_addr[3], 7'd47);
      check("t2_r47_b", log_addr[4], 7'd47);
      check("t2_r47_c", log_addr[5], 7'd47);
      check("t2_next_r4", log_addr[6], 7'd4);
    end
    check("t2_init_error", init_error, 0);
    check("t2_err_index", init_error_index, 4'hF);

    // Step 3: entry 5 always NACKs
    restart(7'd7, -1);
    wait_init_done("t3_init_done");
    r7_count = 0;
    foreach (log_addr[i]) if (log_addr[i] == 7'd7) r7_count++;
    check("t3_r7_issues", r7_count, 4);
    check("t3_count", log_addr.size(), 12);
    if (log_addr.size() == 12) begin
      check("t3_tail_r5", log_addr[9], 7'd5);
      check("t3_tail_r34", log_addr[10], 7'd34);
      check("t3_tail_r37", log_addr[11], 7'd37);
    end
    check("t3_init_error", init_error, 1);
    check("t3_err_index", init_error_index, 4'd5);

    // Step 5: reset pulse during entry 2 (entry 1 failed first, so error flags are set)
    restart(7'd25, -1);
    for (int i = 0; i < 500 && log_addr.size() < 6; i++) @(negedge clk);
    check("t5_reached_entry2", log_addr.size(), 6);
    if (log_addr.size() == 6) check("t5_entry2_addr", log_addr[5], 7'd26);
    check("t5_pre_error", init_error, 1);
    check("t5_pre_index", init_error_index, 4'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5_rst_din_valid", i2c_din_valid, 0);
    check("t5_rst_dout_ready", i2c_dout_ready, 0);
    check("t5_rst_init_error", init_error, 0);
    check("t5_rst_err_index", init_error_index, 4'hF);
    check("t5_rst_init_done", init_done, 0);
    check("t5_rst_reg_addr", i2c_register_address, 0);
    check("t5_rst_dev_addr", i2c_device_address, 7'h1A);
    nack_addr = 7'h7F; nack_left = 0;
    @(negedge clk);
    log_addr.delete(); log_data.delete(); log_rw.delete(); log_cyc.delete();
    reset_n = 1'b1;
    wait_init_done("t5_init_done");
    check("t5_count", log_addr.size(), 9);
    if (log_addr.size() > 0) check("t5_first_r15", log_addr[0], 7'd15);
    check("t5_init_error", init_error, 0);

`ifdef WM8960_SEQ_TIMEOUT_EN
    // Step 6: host write never answered -> watchdog response after TIMEOUT wait cycles
    silent = 1'b1;
    host_rd_wr = 1'b0; host_reg_addr = 7'd4; host_reg_data = 9'h055; host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    wcount = 0;
    for (int i = 0; i < 300 && host_rsp_valid !== 1'b1; i++) begin
      @(negedge clk);
      if (i2c_dout_ready) wcount++;
    end
    check("t6_rsp_valid", host_rsp_valid, 1);
    check("t6_wait_cycles", wcount, TIMEOUT);
    check("t6_rsp_acks", host_rsp_acks, 3'b000);
    check("t6_rsp_data", host_rsp_data, 9'd0);
    host_rsp_ready = 1'b1;
    @(negedge clk);
    host_rsp_ready = 1'b0;
    silent = 1'b0;
`else
    wcount = 0;
    check("t6_no_watchdog_wcount", wcount, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
